// File: rtl/demux_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_feeder_pkg
// Brief    : Shared constants and FSM state type for the serial demux feeder.
// Revision : 1.0
// ============================================================================
package demux_feeder_pkg;

    localparam int SEL_W     = 3;
    localparam int ADDR_BITS = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        DATA   = 2'd2,
        PARITY = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/frame_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : frame_bit_counter
// Brief    : Saturating bit counter with clear, increment and terminal flag.
// Revision : 1.0
// ============================================================================
module frame_bit_counter #(
    parameter int WIDTH    = 2,
    parameter int TERMINAL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_incr,
    output logic o_terminal
);

    logic [WIDTH-1:0] r_count;

    assign o_terminal = (r_count == WIDTH'(TERMINAL));

    // Holds at the terminal value; the owner clears it at the next frame start.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_incr && !o_terminal) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_demux_feeder.sv
`default_nettype none
// ============================================================================
// Module   : serial_demux_feeder
// Brief    : Deframes start/address/payload/parity bit stream onto a 1:8 demux.
// Revision : 1.0
// ============================================================================
module serial_demux_feeder #(
    parameter int PAYLOAD_LEN = 8,
    parameter int SEL_W       = demux_feeder_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic             rx_bit,
    output logic             rx_ready,
    input  logic             stall,
    output logic             demux_in,
    output logic [SEL_W-1:0] demux_sel,
    output logic             demux_en,
    output logic             frame_done,
    output logic             frame_err
);

    import demux_feeder_pkg::*;

    localparam int c_PAY_CNT_W = $clog2(PAYLOAD_LEN + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [SEL_W-2:0] r_addr_part;
    logic             r_parity;
    logic             w_accept;
    logic             w_start;
    logic             w_addr_term;
    logic             w_pay_term;

    assign rx_ready = ~stall;
    assign w_accept = rx_valid & ~stall;
    assign w_start  = w_accept && (r_state == IDLE) && rx_bit;

    frame_bit_counter #(
        .WIDTH    ($clog2(ADDR_BITS + 1)),
        .TERMINAL (ADDR_BITS - 1)
    ) u_addr_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_start),
        .i_incr     (w_accept && (r_state == ADDR)),
        .o_terminal (w_addr_term)
    );

    frame_bit_counter #(
        .WIDTH    (c_PAY_CNT_W),
        .TERMINAL (PAYLOAD_LEN - 1)
    ) u_pay_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_start),
        .i_incr     (w_accept && (r_state == DATA)),
        .o_terminal (w_pay_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start)                  w_state_next = ADDR;
            ADDR:    if (w_accept && w_addr_term)  w_state_next = DATA;
            DATA:    if (w_accept && w_pay_term)   w_state_next = PARITY;
            PARITY:  if (w_accept)                 w_state_next = IDLE;
            default:                               w_state_next = IDLE;
        endcase
    end

    // Outputs are registered, so each accepted bit shows up one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            demux_in    <= 1'b0;
            demux_sel   <= '0;
            demux_en    <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            r_addr_part <= '0;
            r_parity    <= 1'b0;
        end else begin
            demux_en   <= w_accept && (r_state == DATA);
            demux_in   <= w_accept && (r_state == DATA) && rx_bit;
            frame_done <= w_accept && (r_state == PARITY);
            frame_err  <= w_accept && (r_state == PARITY) && (r_parity ^ rx_bit);

            if (w_start) begin
                r_parity <= 1'b0;
            end else if (w_accept && ((r_state == ADDR) || (r_state == DATA))) begin
                r_parity <= r_parity ^ rx_bit;
            end

            if (w_accept && (r_state == ADDR)) begin
                r_addr_part <= {r_addr_part[SEL_W-3:0], rx_bit};
                if (w_addr_term) begin
                    demux_sel <= {r_addr_part, rx_bit};
                end
            end
        end
    end

endmodule
`default_nettype wire
